// File: rtl/fport_channel_unpacker_if.sv
// Byte-stream input and channel/status outputs of the F.Port channel unpacker.
// Handshake: byte_valid is a one-cycle strobe qualifying byte_data; the unpacker has no
// backpressure (ready is implicitly always 1), and channel_changed likewise qualifies index/value.
interface fport_channel_unpacker_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        channel_changed;
  logic [3:0]  channel_index;
  logic [10:0] channel_value;
  logic        failsafe;
  logic        frame_lost;
  logic [7:0]  rssi;
  logic        frame_ok;
  logic        crc_error;
  logic        link_ok;
  logic [2:0]  parser_state;

  modport master (
    output byte_valid, byte_data,
    input  channel_changed, channel_index, channel_value, failsafe, frame_lost,
           rssi, frame_ok, crc_error, link_ok, parser_state
  );

  modport slave (
    input  byte_valid, byte_data,
    output channel_changed, channel_index, channel_value, failsafe, frame_lost,
           rssi, frame_ok, crc_error, link_ok, parser_state
  );
endinterface

// File: rtl/fport_channel_unpacker.sv
// F.Port control-frame parser: de-stuffs, checks the additive CRC, and reports each
// changed 11-bit channel once per accepted frame via a 16-cycle emitter walk.
module fport_channel_unpacker #(
  parameter int CLOCK_FREQUENCY     = 12_000_000,
  parameter int BYTE_TIMEOUT_CLOCKS = CLOCK_FREQUENCY / 1000,
  parameter int LINK_TIMEOUT_CLOCKS = CLOCK_FREQUENCY / 10
) (
  input  logic                     clock,
  input  logic                     reset_n,
  fport_channel_unpacker_if.slave  bus
);

  localparam int BW = $clog2(BYTE_TIMEOUT_CLOCKS + 1);
  localparam int LW = $clog2(LINK_TIMEOUT_CLOCKS + 1);

  typedef enum logic [2:0] {
    S_HUNT, S_LEN, S_TYPE, S_DATA, S_FLAGS, S_RSSI, S_CHECK
  } state_e;

  state_e        state_q, state_d;
  logic          esc_q, esc_d;
  logic [7:0]    acc_q, acc_d;
  logic [4:0]    data_idx_q, data_idx_d;
  logic [175:0]  payload_q, payload_d;
  logic [1:0]    flags_q, flags_d;
  logic [7:0]    rssi_rx_q, rssi_rx_d;
  logic [BW-1:0] idle_q, idle_d;

  logic          frame_ok_q, frame_ok_d;
  logic          crc_error_q, crc_error_d;
  logic          failsafe_q, failsafe_d;
  logic          frame_lost_q, frame_lost_d;
  logic [7:0]    rssi_q, rssi_d;
  logic          link_ok_q, link_ok_d;
  logic [LW-1:0] link_cnt_q, link_cnt_d;

  logic [175:0]  emit_q, emit_d;
  logic          walk_q, walk_d;
  logic [3:0]    ch_q, ch_d;
  logic          changed_q, changed_d;
  logic [3:0]    idx_q, idx_d;
  logic [10:0]   val_q, val_d;
  logic [10:0]   shadow_q [16];
  logic [10:0]   shadow_d [16];
  logic [15:0]   sv_q, sv_d;

  logic          good, bad;
  logic [7:0]    b;
  logic [7:0]    data_base;
  logic [7:0]    emit_base;
  logic [10:0]   ch_val;

  // End-around-carry add; the folded result never exceeds 0xFF.
  function automatic logic [7:0] fold_add(input logic [7:0] acc, input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, acc} + {1'b0, v};
    return s[7:0] + {7'd0, s[8]};
  endfunction

  assign b         = bus.byte_data ^ (esc_q ? 8'h20 : 8'h00);
  assign data_base = {data_idx_q, 3'b000};
  assign emit_base = 8'(ch_q) * 8'd11;
  assign ch_val    = emit_q[emit_base +: 11];

  always_comb begin
    state_d    = state_q;
    esc_d      = esc_q;
    acc_d      = acc_q;
    data_idx_d = data_idx_q;
    payload_d  = payload_q;
    flags_d    = flags_q;
    rssi_rx_d  = rssi_rx_q;
    idle_d     = idle_q;
    good       = 1'b0;
    bad        = 1'b0;

    if (bus.byte_valid) begin
      idle_d = '0;
      if (state_q == S_HUNT) begin
        if (bus.byte_data == 8'h7E) begin
          state_d = S_LEN;
          acc_d   = '0;
          esc_d   = 1'b0;
        end
      end else if (bus.byte_data == 8'h7E && !esc_q) begin
        state_d = S_LEN;
        acc_d   = '0;
        esc_d   = 1'b0;
      end else if (bus.byte_data == 8'h7D && !esc_q) begin
        esc_d = 1'b1;
      end else begin
        esc_d = 1'b0;
        acc_d = fold_add(acc_q, b);
        unique case (state_q)
          S_LEN:   state_d = (b == 8'h19) ? S_TYPE : S_HUNT;
          S_TYPE: begin
            state_d    = (b == 8'h00) ? S_DATA : S_HUNT;
            data_idx_d = '0;
          end
          S_DATA: begin
            payload_d[data_base +: 8] = b;
            data_idx_d = data_idx_q + 5'd1;
            if (data_idx_q == 5'd21) state_d = S_FLAGS;
          end
          S_FLAGS: begin
            flags_d = b[3:2];
            state_d = S_RSSI;
          end
          S_RSSI: begin
            rssi_rx_d = b;
            state_d   = S_CHECK;
          end
          S_CHECK: begin
            good    = (fold_add(acc_q, b) == 8'hFF);
            bad     = !good;
            state_d = S_HUNT;
          end
          default: state_d = S_HUNT;
        endcase
      end
    end else begin
      if (idle_q != BW'(BYTE_TIMEOUT_CLOCKS)) idle_d = idle_q + 1'b1;
      if (state_q != S_HUNT && idle_q == BW'(BYTE_TIMEOUT_CLOCKS)) begin
        state_d = S_HUNT;
        esc_d   = 1'b0;
      end
    end
  end

  always_comb begin
    frame_ok_d   = good;
    crc_error_d  = bad;
    failsafe_d   = failsafe_q;
    frame_lost_d = frame_lost_q;
    rssi_d       = rssi_q;
    link_ok_d    = link_ok_q;
    link_cnt_d   = link_cnt_q;
    emit_d       = emit_q;
    walk_d       = walk_q;
    ch_d         = ch_q;
    changed_d    = 1'b0;
    idx_d        = idx_q;
    val_d        = val_q;
    shadow_d     = shadow_q;
    sv_d         = sv_q;

    if (good) begin
      failsafe_d   = flags_q[1];
      frame_lost_d = flags_q[0];
      rssi_d       = rssi_rx_q;
      link_ok_d    = 1'b1;
      link_cnt_d   = '0;
    end else if (link_ok_q) begin
      if (link_cnt_q == LW'(LINK_TIMEOUT_CLOCKS - 1)) link_ok_d = 1'b0;
      else link_cnt_d = link_cnt_q + 1'b1;
    end

    // A new frame reloads the emit register and restarts the walk from channel 0.
    if (good) begin
      emit_d = payload_q;
      walk_d = 1'b1;
      ch_d   = '0;
    end else if (walk_q) begin
      if (!sv_q[ch_q] || ch_val != shadow_q[ch_q]) begin
        changed_d      = 1'b1;
        idx_d          = ch_q;
        val_d          = ch_val;
        shadow_d[ch_q] = ch_val;
        sv_d[ch_q]     = 1'b1;
      end
      ch_d = ch_q + 4'd1;
      if (ch_q == 4'd15) walk_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_HUNT;
      esc_q        <= 1'b0;
      acc_q        <= '0;
      data_idx_q   <= '0;
      payload_q    <= '0;
      flags_q      <= '0;
      rssi_rx_q    <= '0;
      idle_q       <= '0;
      frame_ok_q   <= 1'b0;
      crc_error_q  <= 1'b0;
      failsafe_q   <= 1'b0;
      frame_lost_q <= 1'b0;
      rssi_q       <= '0;
      link_ok_q    <= 1'b0;
      link_cnt_q   <= '0;
      emit_q       <= '0;
      walk_q       <= 1'b0;
      ch_q         <= '0;
      changed_q    <= 1'b0;
      idx_q        <= '0;
      val_q        <= '0;
      sv_q         <= '0;
      for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      esc_q        <= esc_d;
      acc_q        <= acc_d;
      data_idx_q   <= data_idx_d;
      payload_q    <= payload_d;
      flags_q      <= flags_d;
      rssi_rx_q    <= rssi_rx_d;
      idle_q       <= idle_d;
      frame_ok_q   <= frame_ok_d;
      crc_error_q  <= crc_error_d;
      failsafe_q   <= failsafe_d;
      frame_lost_q <= frame_lost_d;
      rssi_q       <= rssi_d;
      link_ok_q    <= link_ok_d;
      link_cnt_q   <= link_cnt_d;
      emit_q       <= emit_d;
      walk_q       <= walk_d;
      ch_q         <= ch_d;
      changed_q    <= changed_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      sv_q         <= sv_d;
      for (int i = 0; i < 16; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign bus.channel_changed = changed_q;
  assign bus.channel_index   = idx_q;
  assign bus.channel_value   = val_q;
  assign bus.failsafe        = failsafe_q;
  assign bus.frame_lost      = frame_lost_q;
  assign bus.rssi            = rssi_q;
  assign bus.frame_ok        = frame_ok_q;
  assign bus.crc_error       = crc_error_q;
  assign bus.link_ok         = link_ok_q;
  assign bus.parser_state    = state_q;

endmodule

// File: tb/tb_fport_channel_unpacker.sv
// Scoreboard bench for the F.Port channel unpacker: frames are built and stuffed here,
// expected channel updates are queued at send time and popped as the DUT reports them.
module tb_fport_channel_unpacker;
  localparam int BT = 100;
  localparam int LT = 3000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fport_channel_unpacker_if bus();

  fport_channel_unpacker #(
    .BYTE_TIMEOUT_CLOCKS(BT),
    .LINK_TIMEOUT_CLOCKS(LT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int pulse_cnt = 0;
  int first_pulse_cyc = 0;
  int last_pulse_cyc = 0;
  int last_ok_cyc = 0;

  logic [14:0] exp_q[$];
  logic [10:0] cur_ch [16];
  logic [10:0] m_shadow [16];
  logic [15:0] m_valid = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: counts status pulses and pops the scoreboard on every channel update.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.frame_ok) begin
        ok_cnt++;
        last_ok_cyc = cyc;
      end
      if (bus.crc_error) err_cnt++;
      if (bus.channel_changed) begin
        pulse_cnt++;
        if (pulse_cnt == 1) first_pulse_cyc = cyc;
        last_pulse_cyc = cyc;
        if (exp_q.size() == 0) check("chg_spurious", 32'(bus.channel_changed), 32'd0);
        else check("chg", {17'd0, bus.channel_index, bus.channel_value}, {17'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] v, input int gap);
    @(negedge clock);
    bus.byte_valid = 1'b1;
    bus.byte_data  = v;
    @(negedge clock);
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_stuffed(input logic [7:0] v, input int gap);
    if (v == 8'h7E || v == 8'h7D) begin
      send_byte(8'h7D, gap);
      send_byte(v ^ 8'h20, gap);
    end else begin
      send_byte(v, gap);
    end
  endtask

  // Sends cur_ch as a frame; a non-zero crc_delta corrupts the CRC byte.
  task automatic send_frame(input logic [7:0] flags, input logic [7:0] rssi,
                            input int crc_delta, input int max_gap, input int n_data);
    logic [175:0] p;
    logic [7:0]   body [27];
    int s;
    for (int k = 0; k < 16; k++) p[11*k +: 11] = cur_ch[k];
    body[0] = 8'h19;
    body[1] = 8'h00;
    for (int i = 0; i < 22; i++) body[2+i] = p[8*i +: 8];
    body[24] = flags;
    body[25] = rssi;
    s = 0;
    for (int i = 0; i < 26; i++) begin
      s = s + body[i];
      s = (s & 255) + (s >> 8);
    end
    body[26] = 8'(255 - s + crc_delta);
    if (crc_delta == 0 && n_data == 22) begin
      for (int k = 0; k < 16; k++) begin
        if (!m_valid[k] || cur_ch[k] != m_shadow[k]) begin
          exp_q.push_back({4'(k), cur_ch[k]});
          m_shadow[k] = cur_ch[k];
          m_valid[k]  = 1'b1;
        end
      end
    end
    send_byte(8'h7E, $urandom_range(max_gap, 0));
    for (int i = 0; i < 2 + n_data; i++) send_stuffed(body[i], $urandom_range(max_gap, 0));
    if (n_data == 22)
      for (int i = 24; i < 27; i++) send_stuffed(body[i], $urandom_range(max_gap, 0));
  endtask

  task automatic drain();
    repeat (30) @(negedge clock);
  endtask

  int ok0, err0, n;

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (5) @(negedge clock);
    check("rst_changed", 32'(bus.channel_changed), 0);
    check("rst_index", 32'(bus.channel_index), 0);
    check("rst_value", 32'(bus.channel_value), 0);
    check("rst_rssi", 32'(bus.rssi), 0);
    check("rst_link", 32'(bus.link_ok), 0);
    check("rst_status", {28'd0, bus.failsafe, bus.frame_lost, bus.frame_ok, bus.crc_error}, 0);
    check("rst_state", 32'(bus.parser_state), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // All channels 992: 16 consecutive updates starting the cycle after frame_ok.
    for (int k = 0; k < 16; k++) cur_ch[k] = 11'd992;
    pulse_cnt = 0;
    send_frame(8'h00, 8'h64, 0, 0, 22);
    drain();
    check("t1_frame_ok", ok_cnt, 1);
    check("t1_pulses", pulse_cnt, 16);
    check("t1_span", last_pulse_cyc - first_pulse_cyc, 15);
    check("t1_latency", first_pulse_cyc - last_ok_cyc, 1);
    check("t1_rssi", 32'(bus.rssi), 32'h64);
    check("t1_link", 32'(bus.link_ok), 1);
    check("t1_queue", exp_q.size(), 0);

    // Only channel 5 changes.
    cur_ch[5] = 11'd1811;
    pulse_cnt = 0;
    send_frame(8'h00, 8'h64, 0, 2, 22);
    drain();
    check("t2_frame_ok", ok_cnt, 2);
    check("t2_pulses", pulse_cnt, 1);
    check("t2_queue", exp_q.size(), 0);

    // Corrupted CRC: rejected, nothing else moves.
    cur_ch[3] = 11'd5;
    pulse_cnt = 0;
    send_frame(8'h0C, 8'h33, 1, 1, 22);
    drain();
    check("t3_crc_error", err_cnt, 1);
    check("t3_frame_ok", ok_cnt, 2);
    check("t3_pulses", pulse_cnt, 0);
    check("t3_rssi", 32'(bus.rssi), 32'h64);
    check("t3_flags", {30'd0, bus.failsafe, bus.frame_lost}, 0);
    cur_ch[3] = 11'd992;

    // Channel 0 = 0x07E puts a raw 0x7E in data byte 0, sent stuffed.
    cur_ch[0] = 11'h07E;
    cur_ch[1] = 11'h3EF;
    pulse_cnt = 0;
    send_frame(8'h04, 8'h50, 0, 1, 22);
    drain();
    check("t4_frame_ok", ok_cnt, 3);
    check("t4_rssi", 32'(bus.rssi), 32'h50);
    check("t4_frame_lost", 32'(bus.frame_lost), 1);
    check("t4_queue", exp_q.size(), 0);

    // Truncated frame abandoned by the byte timeout, then a good random frame.
    send_frame(8'h00, 8'h10, 0, 0, 10);
    repeat (BT + 20) @(negedge clock);
    check("t5_hunt", 32'(bus.parser_state), 0);
    ok0 = ok_cnt;
    err0 = err_cnt;
    for (int k = 0; k < 16; k++) cur_ch[k] = 11'($urandom_range(2047, 0));
    send_frame(8'h00, 8'h21, 0, 2, 22);
    drain();
    check("t5_frame_ok", ok_cnt - ok0, 1);
    check("t5_crc_error", err_cnt - err0, 0);
    check("t5_queue", exp_q.size(), 0);

    // A few random frames with random byte spacing.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++)
        if ($urandom_range(1, 0) == 1) cur_ch[k] = 11'($urandom_range(2047, 0));
      send_frame(8'h00, 8'($urandom_range(255, 0)), 0, 2, 22);
      drain();
    end
    check("rand_queue", exp_q.size(), 0);

    // Reset mid-walk invalidates the shadow: the same frame then reports all 16 channels.
    pulse_cnt = 0;
    for (int k = 0; k < 16; k++) cur_ch[k] = 11'(100 + k);
    send_frame(8'h00, 8'h44, 0, 0, 22);
    for (n = 0; n < 200 && pulse_cnt < 3; n++) @(negedge clock);
    check("t6_walk_started", 32'(pulse_cnt >= 3), 1);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    exp_q.delete();
    m_valid = '0;
    check("t6_rst_link", 32'(bus.link_ok), 0);
    check("t6_rst_changed", 32'(bus.channel_changed), 0);
    reset_n = 1'b1;
    @(negedge clock);
    pulse_cnt = 0;
    send_frame(8'h00, 8'h44, 0, 1, 22);
    drain();
    check("t6_pulses", pulse_cnt, 16);
    check("t6_queue", exp_q.size(), 0);

    // Failsafe frame, then silence until the link drops.
    ok0 = ok_cnt;
    send_frame(8'h08, 8'h64, 0, 0, 22);
    for (n = 0; n < 40 && ok_cnt == ok0; n++) @(negedge clock);
    check("t7_frame_ok", ok_cnt - ok0, 1);
    check("t7_failsafe", 32'(bus.failsafe), 1);
    check("t7_frame_lost", 32'(bus.frame_lost), 0);
    check("t7_link_up", 32'(bus.link_ok), 1);
    for (n = 0; n < LT + 100 && bus.link_ok; n++) @(negedge clock);
    check("t7_link_down", 32'(bus.link_ok), 0);
    check("t7_link_time", cyc - last_ok_cyc, LT);
    check("t7_failsafe_hold", 32'(bus.failsafe), 1);
    check("t7_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fport_channel_unpacker.md
Name: fport_channel_unpacker

Overview:
- Consumes the decoded byte stream from the F.Port receive UART.
- Frames and de-stuffs F.Port control frames, checks the CRC, and unpacks the 16 11-bit channels.
- Emits one channel_changed/channel_index/channel_value update per channel whose value differed from the previous accepted frame.
- Sits between the uplink byte receiver and the channel consumers (servo/motor command logic). Also reports flags, RSSI and link status.

Parameters:
clock_frequency, 12000000, system clock in Hz
byte_timeout_clocks, clock_frequency/1000, idle clocks (1 ms) after which a partial frame is abandoned
link_timeout_clocks, clock_frequency/10, clocks (100 ms) without a good frame before link_ok drops

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
byte_valid  in  1  one-cycle strobe, byte_data valid
byte_data  in  8  received byte, already un-inverted
channel_changed  out  1  one-cycle pulse, channel_index/channel_value valid
channel_index  out  4  channel number 0..15
channel_value  out  11  channel value 0..2047
failsafe  out  1  flags bit 3 of last good frame
frame_lost  out  1  flags bit 2 of last good frame
rssi  out  8  RSSI byte of last good frame
frame_ok  out  1  pulse on each accepted frame
crc_error  out  1  pulse on each CRC-failed frame
link_ok  out  1  high while good frames arrive within link_timeout_clocks

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-low (reset_n).
- Reset values: all outputs 0; shadow-valid bits cleared; parser state HUNT; emitter idle.
- Frame format, after de-stuffing: 0x7E, LEN=0x19, TYPE=0x00, 22 data bytes, FLAGS, RSSI, CRC.
- Byte stuffing, in every state except HUNT:
  - Raw 0x7D sets an escape flag and is consumed.
  - The next byte is XORed with 0x20.
  - An unescaped raw 0x7E mid-frame resynchronises: go to LEN and clear the CRC accumulator.
- Parser states:
  - HUNT: wait for 0x7E, then go to LEN.
  - LEN: 0x19 -> TYPE. Raw 0x7E -> stay in LEN. Anything else -> HUNT.
  - TYPE: 0x00 -> DATA. Anything else -> HUNT.
  - DATA: store bytes 0..21 into the 176-bit payload buffer; byte i occupies bits 8i+7..8i. After byte 21 -> FLAGS.
  - FLAGS -> RSSI -> CHECK.
  - CHECK: the received byte is the CRC. Evaluate, then go to HUNT.
- CRC:
  - 9-bit accumulator cleared on LEN entry. Each de-stuffed byte from LEN through RSSI is added, then the carry is folded back: acc = acc[7:0] + acc[8].
  - Frame is good when fold(acc + CRC) == 0xFF.
  - Good frame: pulse frame_ok, latch failsafe/frame_lost/rssi, copy payload to the emit register, start the emitter, restart the link timer.
  - Bad frame: pulse crc_error; no other output changes.
- Byte timeout: an idle counter is reset by every byte_valid. In any state except HUNT, reaching byte_timeout_clocks forces HUNT. No error pulse.
- Link: link_ok is set on frame_ok. It is cleared when link_timeout_clocks elapse with no frame_ok.
- Emitter:
  - Starts the cycle after frame_ok and walks k = 0..15, one channel per cycle.
  - Value_k = emit register bits 11k+10..11k (SBUS little-endian packing).
  - If shadow-valid[k] is 0 or value_k != shadow[k]: drive channel_changed=1 with index k and value value_k, then update shadow[k] and set shadow-valid[k].
  - Otherwise channel_changed=0 that cycle.
  - The walk takes exactly 16 cycles. Index and value hold their last driven value when no pulse is issued.
- Simultaneous events:
  - Parsing continues while the emitter runs, because the emit register is separate from the payload buffer.
  - If a new frame_ok arrives mid-walk, the emit register is reloaded and the walk restarts at k=0. Unvisited channels are compared against the new frame.
- Reset mid-frame or mid-walk: returns to reset values immediately; the shadow is invalidated.

Test Plan:
- Reset, then a valid frame with all channels 992, flags 0x00, RSSI 0x64 -> frame_ok pulse; 16 channel_changed pulses on consecutive cycles, index 0..15, value 992; rssi=0x64; link_ok=1.
- The same frame again, with only channel 5 = 1811 -> exactly one channel_changed: index 5, value 1811.
- Frame whose CRC byte is off by 1 -> crc_error pulse, no frame_ok, no channel_changed, rssi unchanged.
- Frame with a data byte 0x7E sent stuffed as 0x7D 0x5E -> accepted; unpacked channels match the un-stuffed payload.
- Frame truncated after 10 data bytes, idle > byte_timeout_clocks, then a valid frame -> the valid frame is accepted and exactly one frame_ok is seen.
- Valid frame with FLAGS=0x08, then no frames for link_timeout_clocks -> failsafe=1; link_ok falls exactly link_timeout_clocks after frame_ok.
